ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 106 ++++++++++
 tb/tb_ram_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Single-port word memory with a request/response handshake.
// Memory is swept to zero after reset and on clear_req; requests are served one per cycle when idle.
module ram_ctrl #(
  parameter int  WORD_SIZE     = 21,
  parameter int  WORD_QUANTITY = 33,
  localparam int ADDR_W        = $clog2(WORD_QUANTITY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_type,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 clear_req,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 busy
);

  // One extra bit so the bound still fits when WORD_QUANTITY is a power of two.
  localparam logic [ADDR_W:0]   QTY  = (ADDR_W + 1)'(WORD_QUANTITY);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORD_QUANTITY - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    cnt_reg, cnt_next;
  logic [WORD_SIZE-1:0] mem [WORD_QUANTITY];

  logic                 in_range;
  logic                 accept;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  assign in_range = {1'b0, addr} < QTY;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    req_ready  = 1'b0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;
    case (state_reg)
      CLEAR: begin
        // clear_req is ignored here so an ongoing sweep is never restarted.
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        if (cnt_reg == LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      IDLE: begin
        req_ready = !clear_req;
        accept    = req_valid && !clear_req;
        mem_we    = accept && req_type && in_range;
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      data_out  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rsp_valid <= accept;
      rsp_err   <= accept && !in_range;
      if (accept && !req_type && in_range) begin
        data_out <= mem[addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: reset sweep, read/write/error responses,
// clear handling, asynchronous reset aborts and back-to-back streaming.
module tb_ram_ctrl;

  localparam int WS = 21;
  localparam int WQ = 33;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_type;
  logic [AW-1:0] addr;
  logic [WS-1:0] data_in;
  logic          clear_req;
  logic          rsp_valid;
  logic          rsp_err;
  logic [WS-1:0] data_out;
  logic          busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int n;

  ram_ctrl #(.WORD_SIZE(WS), .WORD_QUANTITY(WQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .addr      (addr),
    .data_in   (data_in),
    .clear_req (clear_req),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one request for one edge, then check its response right after that edge.
  task automatic req(input logic wr, input int a, input int d, input logic exp_err,
                     input int exp_dout, input string tag);
    req_valid = 1'b1;
    req_type  = wr;
    addr      = a[AW-1:0];
    data_in   = d[WS-1:0];
    @(posedge clk); #1;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, "_data_out"}, {11'd0, data_out}, exp_dout);
    $display("txn %s: wr=%0d addr=%0d data_in=%0h rsp_err=%0d data_out=%0h",
             tag, wr, a, d, rsp_err, data_out);
  endtask

  task automatic idle_cycle(input string tag);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  // Counts edges until busy drops; the bound keeps a stuck DUT from hanging the run.
  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_type  = 1'b0;
    addr      = '0;
    data_in   = '0;
    clear_req = 1'b0;

    // Reset state, observed before any clock edge.
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_data_out", {11'd0, data_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    wait_sweep(n);
    chk("init_sweep_len", n, 32'd33);
    chk("init_req_ready", {31'd0, req_ready}, 32'd1);

    // Every word reads back zero after the initial sweep.
    for (int a = 0; a < WQ; a++) req(1'b0, a, 0, 1'b0, 0, "init_rd");
    idle_cycle("idle0");

    // Write then read-after-write on the next cycle.
    req(1'b1, 5, 'h1ABCDE, 1'b0, 0, "wr5");
    req(1'b0, 5, 0, 1'b0, 'h1ABCDE, "rd5");
    idle_cycle("idle1");

    // Out-of-range write and read report an error and touch nothing.
    req(1'b1, 40, 'h00FFFF, 1'b1, 'h1ABCDE, "wr40_err");
    req(1'b0, 32, 0, 1'b0, 0, "rd32");
    req(1'b0, 8, 0, 1'b0, 0, "rd8_alias");
    req(1'b0, 5, 0, 1'b0, 'h1ABCDE, "rd5_again");
    req(1'b0, 63, 0, 1'b1, 'h1ABCDE, "rd63_err");

    // Clear requested alongside a request: request dropped, prior response still issued.
    req(1'b1, 0, 'h155555, 1'b0, 'h1ABCDE, "wr0");
    clear_req = 1'b1;
    req_valid = 1'b1;
    req_type  = 1'b1;
    addr      = '0;
    data_in   = 'h0AAAAA;
    #1;
    chk("clr_req_ready", {31'd0, req_ready}, 32'd0);
    chk("clr_prior_rsp", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("clr_busy", {31'd0, busy}, 32'd1);
    chk("clr_no_accept", {31'd0, rsp_valid}, 32'd0);
    clear_req = 1'b0;
    req_type  = 1'b0;
    addr      = 6'd5;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      clear_req = (n == 10);
      @(posedge clk); #1;
      n++;
      chk("sweep_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("sweep_dout_held", {11'd0, data_out}, 32'h1ABCDE);
    end
    req_valid = 1'b0;
    clear_req = 1'b0;
    chk("clr_sweep_len", n, 32'd33);
    req(1'b0, 0, 0, 1'b0, 0, "rd0_cleared");
    req(1'b0, 5, 0, 1'b0, 0, "rd5_cleared");

    // Reset asserted at sweep counter 10 aborts the sweep and clears outputs at once.
    req(1'b1, 3, 'h777, 1'b0, 0, "wr3");
    req(1'b0, 3, 0, 1'b0, 'h777, "rd3");
    req_valid = 1'b0;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_data_out", {11'd0, data_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_sweep(n);
    chk("midrst_sweep_len", n, 32'd33);

    // Reset right after an accepted request discards its response.
    req(1'b0, 7, 0, 1'b0, 0, "rd7");
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rsprst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_sweep(n);
    chk("rsprst_sweep_len", n, 32'd33);

    // Back-to-back streams: every cycle must carry a response.
    for (int a = 0; a < WQ; a++) req(1'b1, a, a, 1'b0, 0, "stream_wr");
    for (int a = 0; a < WQ; a++) req(1'b0, a, 0, 1'b0, a, "stream_rd");
    idle_cycle("idle_end");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
